// File: rtl/color_rom_arbiter.sv
// Round-robin arbiter sharing one single-port colour-reference ROM among N_REQ requesters.
// It issues one ROM read per cycle and routes each returned byte back to its requester.
module color_rom_arbiter #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [N_REQ-1:0]            gnt,
    output logic [N_REQ-1:0]            rvalid,
    output logic [DATA_WIDTH-1:0]       rdata,
    output logic [ADDR_WIDTH-1:0]       rom_addr,
    input  logic [DATA_WIDTH-1:0]       rom_rd_data,
    output logic                        rom_rst
);

    localparam int unsigned PTR_W = $clog2(N_REQ);
    localparam int unsigned DEPTH = RD_LAT + 1;

    logic [PTR_W-1:0]      ptr_q, ptr_d;
    logic [PTR_W-1:0]      win_id;
    logic [PTR_W-1:0]      idx_w;
    logic                  win_any;
    logic [ADDR_WIDTH-1:0] addr_arr [N_REQ];
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [ADDR_WIDTH-1:0] rom_addr_q;
    logic [DEPTH-1:0]      tag_vld_q;
    logic [PTR_W-1:0]      tag_id_q [DEPTH];
    logic [N_REQ-1:0]      rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  rom_rst_q;

    for (genvar i = 0; i < N_REQ; i++) begin : g_addr
        assign addr_arr[i] = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end

    // Search starts at ptr and wraps modulo N_REQ, so non-power-of-two counts work.
    always_comb begin
        win_any  = 1'b0;
        win_id   = '0;
        idx_w    = '0;
        sel_addr = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx_w = PTR_W'((32'(ptr_q) + k) % N_REQ);
            if (!win_any && req[idx_w]) begin
                win_any  = 1'b1;
                win_id   = idx_w;
                sel_addr = addr_arr[idx_w];
            end
        end
        if (!rst_n) begin
            win_any = 1'b0;
        end
    end

    always_comb begin
        gnt   = '0;
        ptr_d = ptr_q;
        if (win_any) begin
            gnt[win_id] = 1'b1;
            ptr_d       = (win_id == PTR_W'(N_REQ - 1)) ? '0 : win_id + 1'b1;
        end
    end

    always_comb begin
        rvalid_d = '0;
        if (tag_vld_q[DEPTH-1]) begin
            rvalid_d[tag_id_q[DEPTH-1]] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        rom_rst_q <= ~rst_n;
        if (!rst_n) begin
            ptr_q      <= '0;
            rom_addr_q <= '0;
            tag_vld_q  <= '0;
            rvalid_q   <= '0;
            rdata_q    <= '0;
            for (int unsigned k = 0; k < DEPTH; k++) begin
                tag_id_q[k] <= '0;
            end
        end else begin
            ptr_q       <= ptr_d;
            tag_vld_q   <= {tag_vld_q[DEPTH-2:0], win_any};
            tag_id_q[0] <= win_id;
            for (int unsigned k = 1; k < DEPTH; k++) begin
                tag_id_q[k] <= tag_id_q[k-1];
            end
            if (win_any) begin
                rom_addr_q <= sel_addr;
            end
            rvalid_q <= rvalid_d;
            // The tag reaching the last stage lines up with the ROM output for that access.
            if (tag_vld_q[DEPTH-1]) begin
                rdata_q <= rom_rd_data;
            end
        end
    end

    assign rom_addr = rom_addr_q;
    assign rvalid   = rvalid_q;
    assign rdata    = rdata_q;
    assign rom_rst  = rom_rst_q;

endmodule

// File: tb/tb_color_rom_arbiter.sv
// Bench for color_rom_arbiter: directed stimulus pushes expected read returns into
// queues; negedge monitors pop them whenever a DUT raises rvalid.
module tb_color_rom_arbiter;

    typedef struct packed {
        logic [3:0] id;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req1, gnt1, rvalid1;
    logic [43:0] addr1;
    logic [7:0]  rdata1, rom_data1;
    logic [10:0] rom_addr1;
    logic        rom_rst1;
    logic [3:0]  req2, gnt2, rvalid2;
    logic [43:0] addr2;
    logic [7:0]  rdata2, rom_data2, rom2_s0;
    logic [10:0] rom_addr2;
    logic        rom_rst2;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t q1[$];
    exp_t q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM models: data = addr[7:0] ^ 8'hA5, latency 1 and 2.
    always @(posedge clk) rom_data1 <= rom_addr1[7:0] ^ 8'hA5;
    always @(posedge clk) begin
        rom2_s0   <= rom_addr2[7:0] ^ 8'hA5;
        rom_data2 <= rom2_s0;
    end

    color_rom_arbiter #(.N_REQ(4), .ADDR_WIDTH(11), .DATA_WIDTH(8), .RD_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .req(req1), .req_addr(addr1), .gnt(gnt1),
        .rvalid(rvalid1), .rdata(rdata1), .rom_addr(rom_addr1),
        .rom_rd_data(rom_data1), .rom_rst(rom_rst1)
    );

    color_rom_arbiter #(.N_REQ(4), .ADDR_WIDTH(11), .DATA_WIDTH(8), .RD_LAT(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .req(req2), .req_addr(addr2), .gnt(gnt2),
        .rvalid(rvalid2), .rdata(rdata2), .rom_addr(rom_addr2),
        .rom_rd_data(rom_data2), .rom_rst(rom_rst2)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    function automatic logic [43:0] pk(input logic [10:0] a0, input logic [10:0] a1,
                                       input logic [10:0] a2, input logic [10:0] a3);
        return {a3, a2, a1, a0};
    endfunction

    // Drive one cycle on dut1, check the grant, and queue the expected return.
    task automatic step(input logic [3:0] r, input logic [43:0] a, input logic [3:0] eg,
                        input logic [7:0] ed, input bit push);
        exp_t e;
        req1  = r;
        addr1 = a;
        @(negedge clk);
        chk("gnt", 32'(gnt1), 32'(eg));
        if (push && eg != 4'b0) begin
            e.id   = eg;
            e.data = ed;
            e.cyc  = cyc + 3;
            q1.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(4'b0, 44'b0, 4'b0, 8'h00, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req1  = 4'b0;
        req2  = 4'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rvalid1 != 4'b0) begin
            total++;
            if (q1.size() == 0) begin
                bad++;
                $display("FAIL rvalid1_unexpected: got rvalid=%b rdata=%h at cycle %0d required none",
                         rvalid1, rdata1, cyc);
            end else begin
                e = q1.pop_front();
                if (rvalid1 !== e.id || rdata1 !== e.data || cyc != e.cyc) begin
                    bad++;
                    $display("FAIL rvalid1: got id=%b data=%h cyc=%0d required id=%b data=%h cyc=%0d",
                             rvalid1, rdata1, cyc, e.id, e.data, e.cyc);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (rvalid2 != 4'b0) begin
            total++;
            if (q2.size() == 0) begin
                bad++;
                $display("FAIL rvalid2_unexpected: got rvalid=%b rdata=%h at cycle %0d required none",
                         rvalid2, rdata2, cyc);
            end else begin
                e = q2.pop_front();
                if (rvalid2 !== e.id || rdata2 !== e.data || cyc != e.cyc) begin
                    bad++;
                    $display("FAIL rvalid2: got id=%b data=%h cyc=%0d required id=%b data=%h cyc=%0d",
                             rvalid2, rdata2, cyc, e.id, e.data, e.cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t        e;
        logic [3:0]  rot [4];
        logic [7:0]  dat [4];
        rot = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        dat = '{8'hB5, 8'h85, 8'h95, 8'hE5};
        rst_n = 1'b0;
        req1  = 4'b0;
        addr1 = 44'b0;
        req2  = 4'b0;
        addr2 = 44'b0;
        @(posedge clk);
        #1;
        chk("rom_rst_in_reset", 32'(rom_rst1), 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_rvalid", 32'(rvalid1), 32'd0);
        chk("reset_rdata", 32'(rdata1), 32'd0);
        chk("reset_rom_addr", 32'(rom_addr1), 32'd0);
        chk("rom_rst_release", 32'(rom_rst1), 32'd0);

        // Single read by requester 2, then ptr=3 shows up as priority for requester 3.
        step(4'b0100, pk(11'h0, 11'h0, 11'h123, 11'h0), 4'b0100, 8'h86, 1'b1);
        chk("rom_addr_s1", 32'(rom_addr1), 32'h123);
        idle(4);
        step(4'b1001, pk(11'h0AA, 11'h0, 11'h0, 11'h055), 4'b1000, 8'hF0, 1'b1);
        step(4'b1001, pk(11'h0AA, 11'h0, 11'h0, 11'h055), 4'b0001, 8'h0F, 1'b1);
        step(4'b1001, pk(11'h0AA, 11'h0, 11'h0, 11'h055), 4'b1000, 8'hF0, 1'b1);
        idle(4);

        // All requesters held high: strict rotation.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(4'b1111, pk(11'h010, 11'h020, 11'h030, 11'h040), rot[i%4], dat[i%4], 1'b1);
        end
        idle(4);

        // Pointer wraps from 3 to 0 after a lone grant to requester 3.
        do_reset();
        step(4'b1000, pk(11'h0AA, 11'h0, 11'h0, 11'h055), 4'b1000, 8'hF0, 1'b1);
        step(4'b1001, pk(11'h0AA, 11'h0, 11'h0, 11'h055), 4'b0001, 8'h0F, 1'b1);
        step(4'b1001, pk(11'h0AA, 11'h0, 11'h0, 11'h055), 4'b1000, 8'hF0, 1'b1);
        idle(4);

        // Back-to-back reads with address wrap.
        step(4'b0010, pk(11'h0, 11'h7FE, 11'h0, 11'h0), 4'b0010, 8'h5B, 1'b1);
        step(4'b0010, pk(11'h0, 11'h7FF, 11'h0, 11'h0), 4'b0010, 8'h5A, 1'b1);
        step(4'b0010, pk(11'h0, 11'h000, 11'h0, 11'h0), 4'b0010, 8'hA5, 1'b1);
        idle(4);

        // Reset with two reads in flight: they must never return.
        do_reset();
        step(4'b0011, pk(11'h100, 11'h200, 11'h0, 11'h0), 4'b0001, 8'h00, 1'b0);
        step(4'b0011, pk(11'h100, 11'h200, 11'h0, 11'h0), 4'b0010, 8'h00, 1'b0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("gnt_in_reset", 32'(gnt1), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("s5_rom_rst", 32'(rom_rst1), 32'd1);
        chk("s5_rvalid", 32'(rvalid1), 32'd0);
        chk("s5_rdata", 32'(rdata1), 32'd0);
        chk("s5_rom_addr", 32'(rom_addr1), 32'd0);
        step(4'b1010, pk(11'h0, 11'h13C, 11'h0, 11'h077), 4'b0010, 8'h99, 1'b1);
        chk("s5_rom_rst_release", 32'(rom_rst1), 32'd0);
        idle(5);

        // RD_LAT=2 instance: one extra cycle to rvalid.
        req2  = 4'b0100;
        addr2 = pk(11'h0, 11'h0, 11'h123, 11'h0);
        @(negedge clk);
        chk("gnt2", 32'(gnt2), 32'b0100);
        e.id   = 4'b0100;
        e.data = 8'h86;
        e.cyc  = cyc + 4;
        q2.push_back(e);
        @(posedge clk);
        #1;
        req2 = 4'b0;
        chk("rom_addr2", 32'(rom_addr2), 32'h123);
        idle(6);

        chk("q1_drained", 32'(q1.size()), 32'd0);
        chk("q2_drained", 32'(q2.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/color_rom_arbiter.md
# color_rom_arbiter

Round-robin arbiter that shares one single-port 2048×8 colour-reference ROM among several pixel-classification requesters. It sits between the classifier lanes and the ROM IP instance. Each cycle it grants at most one requester, drives the ROM address and tracks the ROM read latency. It then returns the read byte to the correct requester with a one-cycle valid strobe.

## Interface
Parameters:
- N_REQ, 4: number of requesters, 2..8.
- ADDR_WIDTH, 11: ROM address width.
- DATA_WIDTH, 8: ROM data width.
- RD_LAT, 1: ROM read latency in cycles.
  - 1 = ROM without output register.
  - 2 = ROM with output register.
  - Other values are illegal.

Ports:
- clk  in  1  single clock for the block and the ROM.
- rst_n  in  1  synchronous, active-low reset.
- req  in  N_REQ  per-requester read request, level.
- req_addr  in  N_REQ*ADDR_WIDTH  flattened addresses; requester i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- gnt  out  N_REQ  one-hot grant, combinational from req and the priority pointer.
- rvalid  out  N_REQ  one-hot read-data strobe, registered.
- rdata  out  DATA_WIDTH  shared read data, registered; meaningful only while any rvalid bit is high.
- rom_addr  out  ADDR_WIDTH  registered ROM address.
- rom_rd_data  in  DATA_WIDTH  ROM read data.
- rom_rst  out  1  active-high ROM reset; registered as the inverse of rst_n.

## Operation
- **Arbitration.**
  - Priority pointer ptr is log2(N_REQ) bits; reset value 0.
  - The winner is the first i with req[i]=1, searching ptr, ptr+1, … modulo N_REQ.
  - gnt has exactly that one bit set; gnt=0 when req=0.
- **Pointer update.** On the edge where gnt[w]=1, ptr becomes (w+1) mod N_REQ. When no grant occurs, ptr holds.
- **Requester handshake.**
  - A requester holds req and its address stable until it samples gnt high.
  - A requester may keep req high across cycles for back-to-back reads. It is re-granted whenever it wins again.
- **Issue.**
  - On a grant edge, rom_addr loads the winner's address.
  - On the same edge, a tag pipeline loads {valid=1, id=w}.
  - With no grant, rom_addr holds its value and a tag with valid=0 is pushed.
- **Tag pipeline.**
  - Depth is RD_LAT+1 stages and it advances every cycle.
  - When the last stage is valid, the block registers rdata from rom_rd_data and sets rvalid[id]=1 for one cycle.
  - Otherwise rvalid=0 and rdata holds its last value.
- **Throughput.** At most one access per cycle, so at most one rvalid bit is set per cycle. Data returns in issue order.
- **Arithmetic.** ptr increments modulo N_REQ, including for non-power-of-two N_REQ.
- **Reset (rst_n=0 sampled at an edge).**
  - ptr=0, rom_addr=0, all tag valids=0, rvalid=0, rdata=0, rom_rst=1.
  - gnt is forced to 0 while rst_n=0.
  - Any reads in flight are dropped: no rvalid ever appears for them.
  - rom_rst deasserts on the first edge with rst_n=1.

## Timing
- **Grant timing.** gnt is valid in the same cycle t that req is presented, provided the requester wins.
- **Cycle sequence for a grant in cycle t:**
  - t+1: rom_addr = addr.
  - t+1+RD_LAT: rom_rd_data valid.
  - t+2+RD_LAT: rvalid/rdata valid.
  - Grant-to-rvalid latency is therefore RD_LAT+2 cycles (3 for RD_LAT=1).
- **Back-to-back.** Grants in consecutive cycles produce rvalid in consecutive cycles, each carrying its own id.
- **Simultaneous requests.** When all N_REQ requesters are held high from reset, grants go to 0,1,…,N_REQ-1,0,… with one grant per cycle.
- **rst_n with grant.** If rst_n=0 and req are both asserted in the same cycle, there is no grant and ptr stays 0.

## Test plan
ROM model: data = addr[7:0] ^ 8'hA5, latency RD_LAT.

1. **Single requester, single read.** Reset, then req[2]=1 with addr=11'h123 for one cycle. Required response:
   - gnt=4'b0100 that cycle.
   - rom_addr=11'h123 one cycle later.
   - rvalid=4'b0100 with rdata=8'h86 exactly 3 cycles after the grant.
   - ptr=3 afterwards.
2. **All requesters held high.** All four req held high with addrs 0x010, 0x020, 0x030, 0x040 for 8 cycles. Required response:
   - Grants 0,1,2,3,0,1,2,3 in consecutive cycles.
   - rvalid sequence identical, 3 cycles later.
   - rdata sequence B5, 85, 95, E5 repeating.
3. **Pointer wrap with gaps.** Reset, grant requester 3 alone, then req[0]=1 and req[3]=1 together. Required response:
   - Grant goes to 0, because ptr wrapped to 0.
   - Next cycle, grant goes to 3.
4. **Back-to-back single requester.** req[1] held high with the address incrementing 0x7FE, 0x7FF, 0x000. Required response:
   - gnt[1] high for 3 consecutive cycles.
   - rvalid[1] high for 3 consecutive cycles with rdata 5B, 5A, A5.
5. **Reset mid-flight.** Issue two grants, then assert rst_n=0 for 1 cycle before any rvalid. Required response:
   - No rvalid for those reads.
   - All outputs return to their reset values.
   - rom_rst=1 for one cycle.
   - The next request after reset is granted with ptr=0 priority.
6. **RD_LAT=2.** Repeat scenario 1 with RD_LAT=2. Required response: rvalid 4 cycles after the grant, same rdata.
